// File: rtl/vic_video_pkg.sv
// Shared definitions for the VIC-II scan doubler.
// Contents:
//   pass_state_t  read-side sequencer states (IDLE / PASS0 / PASS1)
//   PIX_W         stored pixel width: {blank, colour[3:0]}
//   COL_*         VIC-II colour index names
//   PALETTE       16-entry 12-bit RGB palette ROM, {r[3:0], g[3:0], b[3:0]}
//   palette_rgb() indexed lookup into PALETTE
package vic_video_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS0 = 2'd1,
    ST_PASS1 = 2'd2
  } pass_state_t;

  localparam int PIX_W = 5;

  localparam logic [3:0] COL_BLACK  = 4'h0, COL_WHITE  = 4'h1, COL_RED    = 4'h2, COL_CYAN   = 4'h3;
  localparam logic [3:0] COL_PURPLE = 4'h4, COL_GREEN  = 4'h5, COL_BLUE   = 4'h6, COL_YELLOW = 4'h7;
  localparam logic [3:0] COL_ORANGE = 4'h8, COL_BROWN  = 4'h9, COL_LRED   = 4'hA, COL_DGREY  = 4'hB;
  localparam logic [3:0] COL_GREY   = 4'hC, COL_LGREEN = 4'hD, COL_LBLUE  = 4'hE, COL_LGREY  = 4'hF;

  // Listed from index 15 down to index 0 (packed array, MSB element first).
  localparam logic [15:0][11:0] PALETTE = {
    12'hAAA, 12'h78F, 12'hAF9, 12'h777,
    12'h444, 12'hC76, 12'h540, 12'h853,
    12'hEE7, 12'h43A, 12'h6A5, 12'h849,
    12'h7CC, 12'h833, 12'hFFF, 12'h000
  };

  function automatic logic [11:0] palette_rgb(input logic [3:0] idx);
    return PALETTE[idx];
  endfunction

endpackage

// File: rtl/vic_linebuf.sv
// Ping-pong line buffer: simple dual-port RAM, 2^(ADDR_W+1) x DATA_W.
// The address MSB selects the bank.
// Ports:
//   clk      clock
//   i_we     write enable
//   i_waddr  write address {bank, index}
//   i_wdata  write data
//   i_raddr  read address {bank, index}
//   o_rdata  read data, registered (one cycle after i_raddr)
module vic_linebuf #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 5
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W:0]   i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W:0]   i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int DEPTH = 2 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // NOTE: the storage array has no reset; a reset loop would stop it mapping
  // onto block RAM, and every read is qualified by a reset valid bit downstream.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/vic_scandoubler.sv
// VIC-II scan doubler: stores each input line into one bank of a ping-pong
// buffer while the previous line is replayed twice from the other bank at the
// full dot_clk rate, through the palette to 12-bit RGB.
// Ports:
//   dot_clk       sole clock (2x input pixel rate)
//   reset         synchronous, active-high
//   pix_ce        input pixel strobe
//   color_in      VIC-II colour index
//   blank_in      pixel outside display/border window
//   hsync_in      input line sync (rising edge starts a new line)
//   vsync_in      input frame sync, latched at each line start
//   vga_r/g/b     RGB output, 4 bits each
//   vga_hs        output hsync, first HSYNC_W cycles of each pass
//   vga_vs        output vsync
//   vga_de        output data enable
//   line_len_out  pixel count of the last completed input line
//   line_ovf      sticky: an input line exceeded LINE_LEN pixels
module vic_scandoubler
  import vic_video_pkg::*;
#(
  parameter int LINE_LEN = 512,
  parameter int ADDR_W   = 9,
  parameter int HSYNC_W  = 32
) (
  input  logic            dot_clk,
  input  logic            reset,
  input  logic            pix_ce,
  input  logic [3:0]      color_in,
  input  logic            blank_in,
  input  logic            hsync_in,
  input  logic            vsync_in,
  output logic [3:0]      vga_r,
  output logic [3:0]      vga_g,
  output logic [3:0]      vga_b,
  output logic            vga_hs,
  output logic            vga_vs,
  output logic            vga_de,
  output logic [ADDR_W:0] line_len_out,
  output logic            line_ovf
);

  localparam logic [ADDR_W:0] C_LINE_LEN = (ADDR_W+1)'(LINE_LEN);
  localparam logic [ADDR_W:0] C_HSYNC_W  = (ADDR_W+1)'(HSYNC_W);
  localparam logic [ADDR_W:0] C_ONE      = (ADDR_W+1)'(1);

  // ---------------- write side ----------------
  logic            r_prev_hs, r_wr_bank, r_vs_line, r_ovf;
  logic [ADDR_W:0] r_wr_addr, r_line_len;
  logic            w_hs_edge, w_wr_full, w_we;
  logic [ADDR_W:0] w_waddr;

  assign w_hs_edge = pix_ce & hsync_in & ~r_prev_hs;
  assign w_wr_full = (r_wr_addr == C_LINE_LEN);
  assign w_we      = pix_ce & (w_hs_edge | ~w_wr_full);
  // The line-start pixel goes to address 0 of the bank about to become active.
  assign w_waddr   = w_hs_edge ? {~r_wr_bank, {ADDR_W{1'b0}}}
                               : {r_wr_bank, r_wr_addr[ADDR_W-1:0]};

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, matching the hardware regardless of statement order.
  always_ff @(posedge dot_clk) begin
    if (reset) begin
      r_prev_hs  <= 1'b0;
      r_wr_bank  <= 1'b0;
      r_vs_line  <= 1'b0;
      r_ovf      <= 1'b0;
      r_wr_addr  <= '0;
      r_line_len <= '0;
    end else if (pix_ce) begin
      r_prev_hs <= hsync_in;
      if (w_hs_edge) begin
        r_line_len <= r_wr_addr;
        r_wr_bank  <= ~r_wr_bank;
        r_vs_line  <= vsync_in;
        r_wr_addr  <= C_ONE;
      end else if (w_wr_full) begin
        r_ovf <= 1'b1;
      end else begin
        r_wr_addr <= r_wr_addr + C_ONE;
      end
    end
  end

  // ---------------- read side ----------------
  pass_state_t     r_state, w_state_nxt;
  logic [ADDR_W:0] r_out_addr, w_out_addr_nxt;
  logic            w_in_pass, w_last;
  logic [ADDR_W:0] w_raddr;
  logic [PIX_W-1:0] w_rdata;

  assign w_in_pass = (r_state != ST_IDLE);
  assign w_last    = (r_out_addr == r_line_len - C_ONE);
  assign w_raddr   = {~r_wr_bank, r_out_addr[ADDR_W-1:0]};

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt    = r_state;
    w_out_addr_nxt = r_out_addr;
    if (w_hs_edge) begin
      // A new line abandons whatever pass is running; an empty line never starts.
      w_state_nxt    = (r_wr_addr != '0) ? ST_PASS0 : ST_IDLE;
      w_out_addr_nxt = '0;
    end else begin
      case (r_state)
        ST_PASS0: begin
          if (w_last) begin
            w_state_nxt    = ST_PASS1;
            w_out_addr_nxt = '0;
          end else begin
            w_out_addr_nxt = r_out_addr + C_ONE;
          end
        end
        ST_PASS1: begin
          if (w_last) begin
            w_state_nxt    = ST_IDLE;
            w_out_addr_nxt = '0;
          end else begin
            w_out_addr_nxt = r_out_addr + C_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge dot_clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_out_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_out_addr <= w_out_addr_nxt;
    end
  end

  vic_linebuf #(
    .ADDR_W (ADDR_W),
    .DATA_W (PIX_W)
  ) u_linebuf (
    .clk     (dot_clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata ({blank_in, color_in}),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // ---------------- output pipeline ----------------
  // Stage 1 travels alongside the RAM read; stage 2 alongside the palette register.
  logic        r_s1_valid, r_s1_hs, r_s1_vs;
  logic        r_de, r_hs, r_vs;
  logic [11:0] r_rgb;
  logic        w_vis;

  assign w_vis = r_s1_valid & ~w_rdata[PIX_W-1];

  always_ff @(posedge dot_clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_hs    <= 1'b0;
      r_s1_vs    <= 1'b0;
      r_de       <= 1'b0;
      r_hs       <= 1'b0;
      r_vs       <= 1'b0;
      r_rgb      <= '0;
    end else begin
      r_s1_valid <= w_in_pass;
      r_s1_hs    <= w_in_pass & (r_out_addr < C_HSYNC_W);
      r_s1_vs    <= w_in_pass & r_vs_line;
      r_de       <= w_vis;
      r_hs       <= r_s1_hs;
      r_vs       <= r_s1_vs;
      r_rgb      <= w_vis ? palette_rgb(w_rdata[3:0]) : 12'h000;
    end
  end

  assign vga_r        = r_rgb[11:8];
  assign vga_g        = r_rgb[7:4];
  assign vga_b        = r_rgb[3:0];
  assign vga_hs       = r_hs;
  assign vga_vs       = r_vs;
  assign vga_de       = r_de;
  assign line_len_out = r_line_len;
  assign line_ovf     = r_ovf;

endmodule

// File: tb/tb_vic_scandoubler.sv
// Testbench for vic_scandoubler. Stimulus tasks push the expected output
// stream (one record per dot_clk cycle) into a scoreboard queue; a monitor
// on the falling edge pops and compares each cycle, expecting all-zero
// outputs on cycles with no record.
module tb_vic_scandoubler;

  logic       dot_clk  = 1'b0;
  logic       reset    = 1'b1;
  logic       pix_ce   = 1'b0;
  logic [3:0] color_in = 4'h0;
  logic       blank_in = 1'b0;
  logic       hsync_in = 1'b0;
  logic       vsync_in = 1'b0;
  logic [3:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, vga_de;
  logic [9:0] line_len_out;
  logic       line_ovf;

  vic_scandoubler #(
    .LINE_LEN (512),
    .ADDR_W   (9),
    .HSYNC_W  (32)
  ) dut (
    .dot_clk      (dot_clk),
    .reset        (reset),
    .pix_ce       (pix_ce),
    .color_in     (color_in),
    .blank_in     (blank_in),
    .hsync_in     (hsync_in),
    .vsync_in     (vsync_in),
    .vga_r        (vga_r),
    .vga_g        (vga_g),
    .vga_b        (vga_b),
    .vga_hs       (vga_hs),
    .vga_vs       (vga_vs),
    .vga_de       (vga_de),
    .line_len_out (line_len_out),
    .line_ovf     (line_ovf)
  );

  always #5 dot_clk = ~dot_clk;

  int cyc = 0;
  always @(posedge dot_clk) cyc++;

  typedef struct {
    int          cyc;
    logic [14:0] val;  // {de, hs, vs, rgb[11:0]}
  } exp_t;

  exp_t       exp_q[$];
  logic [4:0] m_line[$];
  logic       m_prev_hs = 1'b0;
  bit         mon_en = 1'b0;
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, exp);
    end
  endtask

  function automatic logic [11:0] pal(input logic [3:0] idx);
    case (idx)
      4'h0: return 12'h000;  4'h1: return 12'hFFF;  4'h2: return 12'h833;  4'h3: return 12'h7CC;
      4'h4: return 12'h849;  4'h5: return 12'h6A5;  4'h6: return 12'h43A;  4'h7: return 12'hEE7;
      4'h8: return 12'h853;  4'h9: return 12'h540;  4'hA: return 12'hC76;  4'hB: return 12'h444;
      4'hC: return 12'h777;  4'hD: return 12'hAF9;  4'hE: return 12'h78F;  default: return 12'hAAA;
    endcase
  endfunction

  // Reference model of one pixel registered at posedge number p.
  task automatic model_pixel(input int p, input logic [4:0] px, input logic hs, input logic vs);
    int len;
    if (hs && !m_prev_hs) begin
      len = m_line.size();
      while (exp_q.size() > 0 && exp_q[$].cyc >= p + 2) void'(exp_q.pop_back());
      for (int i = 0; i < 2 * len; i++) begin
        exp_t       e;
        logic [4:0] d;
        d     = m_line[i % len];
        e.cyc = p + 2 + i;
        e.val = {~d[4], (i % len) < 32, vs, d[4] ? 12'h000 : pal(d[3:0])};
        exp_q.push_back(e);
      end
      m_line.delete();
      m_line.push_back(px);
    end else if (m_line.size() < 512) begin
      m_line.push_back(px);
    end
    m_prev_hs = hs;
  endtask

  task automatic pixel(input logic [3:0] col, input logic blk, input logic hs, input logic vs);
    @(negedge dot_clk);
    pix_ce   = 1'b1;
    color_in = col;
    blank_in = blk;
    hsync_in = hs;
    vsync_in = vs;
    model_pixel(cyc + 1, {blk, col}, hs, vs);
    @(negedge dot_clk);
    pix_ce = 1'b0;
  endtask

  task automatic send_line(input int n, input logic [3:0] col, input int nblank,
                           input logic first_hs, input logic vs);
    for (int k = 0; k < n; k++) pixel(col, k < nblank, (k == 0) && first_hs, vs);
  endtask

  task automatic do_reset();
    int r;
    @(negedge dot_clk);
    pix_ce = 1'b0;
    reset  = 1'b1;
    r      = cyc + 1;
    while (exp_q.size() > 0 && exp_q[$].cyc >= r) void'(exp_q.pop_back());
    m_line.delete();
    m_prev_hs = 1'b0;
    @(negedge dot_clk);
    reset = 1'b0;
  endtask

  always @(negedge dot_clk) begin : monitor
    logic [14:0] expv;
    if (mon_en) begin
      expv = '0;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        check("stale expectation cycle", 32'(exp_q[0].cyc), 32'(cyc));
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        expv = exp_q[0].val;
        void'(exp_q.pop_front());
      end
      check("video {de,hs,vs,rgb}", {vga_de, vga_hs, vga_vs, vga_r, vga_g, vga_b}, expv);
    end
  end

  initial begin
    repeat (3) @(posedge dot_clk);
    @(negedge dot_clk);
    reset  = 1'b0;
    mon_en = 1'b1;
    check("reset line_len_out", line_len_out, 0);
    check("reset line_ovf", line_ovf, 0);

    // hsync with nothing stored: length 0, output stays idle
    pixel(4'h1, 1'b0, 1'b1, 1'b0);
    check("len0 line_len_out", line_len_out, 0);
    repeat (10) @(negedge dot_clk);
    do_reset();

    // 400 x colour 1, then line A (colour 0), line B (colour E)
    send_line(400, 4'h1, 0, 1'b1, 1'b0);
    send_line(400, 4'h0, 0, 1'b1, 1'b0);
    check("400px line_len_out", line_len_out, 400);
    send_line(64, 4'hE, 0, 1'b1, 1'b0);
    check("line A line_len_out", line_len_out, 400);
    // colour 5 with the first 24 pixels blanked
    send_line(64, 4'h5, 24, 1'b1, 1'b0);
    check("line B line_len_out", line_len_out, 64);
    // vsync high on the hsync closing the blanked line, low on the next
    send_line(64, 4'h2, 0, 1'b1, 1'b1);
    check("blank line line_len_out", line_len_out, 64);
    send_line(64, 4'h2, 0, 1'b1, 1'b0);
    check("vsync line line_len_out", line_len_out, 64);
    check("no overflow yet", line_ovf, 0);

    // overflow: 600 pixels, then short lines
    send_line(600, 4'h3, 0, 1'b1, 1'b0);
    check("ovf raised during long line", line_ovf, 1);
    send_line(40, 4'h4, 0, 1'b1, 1'b0);
    check("ovf line_len_out clamped", line_len_out, 512);
    check("ovf sticky 1", line_ovf, 1);
    send_line(40, 4'h4, 0, 1'b1, 1'b0);
    check("short after ovf line_len_out", line_len_out, 40);
    check("ovf sticky 2", line_ovf, 1);

    // reset in the middle of PASS0
    send_line(10, 4'h6, 0, 1'b1, 1'b0);
    do_reset();
    check("post-reset line_len_out", line_len_out, 0);
    check("post-reset line_ovf", line_ovf, 0);
    send_line(20, 4'hA, 0, 1'b0, 1'b0);
    check("no hsync line_len_out", line_len_out, 0);
    send_line(30, 4'h7, 0, 1'b1, 1'b0);
    check("resume line_len_out", line_len_out, 20);

    repeat (200) @(negedge dot_clk);
    check("scoreboard drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
